// File: rtl/cod2outof5_pkg.sv
// Shared types, code-word table and segment patterns for the 2-of-5 scan display.
package cod2outof5_pkg;

    // What a history slot currently holds.
    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DIGIT = 2'd1,
        ERR   = 2'd2
    } entry_state_e;

    typedef struct packed {
        entry_state_e state;
        logic [3:0]   value;
    } entry_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } decode_t;

    localparam entry_t ENTRY_BLANK = '{state: BLANK, value: 4'd0};

    // 2-of-5 code words, {E4..E0}.
    localparam logic [4:0] CW_0 = 5'b00110;
    localparam logic [4:0] CW_1 = 5'b10001;
    localparam logic [4:0] CW_2 = 5'b01001;
    localparam logic [4:0] CW_3 = 5'b11000;
    localparam logic [4:0] CW_4 = 5'b00101;
    localparam logic [4:0] CW_5 = 5'b10100;
    localparam logic [4:0] CW_6 = 5'b01100;
    localparam logic [4:0] CW_7 = 5'b00011;
    localparam logic [4:0] CW_8 = 5'b10010;
    localparam logic [4:0] CW_9 = 5'b01010;

    // Segment patterns, active-high, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h67;
    localparam logic [6:0] SEG_ERR = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Map a code word to its decimal value; anything outside the table is invalid.
    function automatic decode_t decode_2of5(input logic [4:0] code);
        decode_t d;
        d.valid = 1'b1;
        d.value = 4'd0;
        case (code)
            CW_0:    d.value = 4'd0;
            CW_1:    d.value = 4'd1;
            CW_2:    d.value = 4'd2;
            CW_3:    d.value = 4'd3;
            CW_4:    d.value = 4'd4;
            CW_5:    d.value = 4'd5;
            CW_6:    d.value = 4'd6;
            CW_7:    d.value = 4'd7;
            CW_8:    d.value = 4'd8;
            CW_9:    d.value = 4'd9;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Active-high segment pattern for one history entry.
    function automatic logic [6:0] glyph(input entry_t e);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (e.state)
            DIGIT: begin
                case (e.value)
                    4'd0:    seg = SEG_0;
                    4'd1:    seg = SEG_1;
                    4'd2:    seg = SEG_2;
                    4'd3:    seg = SEG_3;
                    4'd4:    seg = SEG_4;
                    4'd5:    seg = SEG_5;
                    4'd6:    seg = SEG_6;
                    4'd7:    seg = SEG_7;
                    4'd8:    seg = SEG_8;
                    4'd9:    seg = SEG_9;
                    default: seg = SEG_OFF;
                endcase
            end
            ERR:     seg = SEG_ERR;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cod2outof5_scan_display_load_debouncer.sv
// Load-key conditioning: 2-FF synchroniser, stability counter and a
// one-cycle push pulse on each accepted 0->1 change of the debounced level.
module load_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic push_o
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             push_q, push_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised key disagrees with the accepted level.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        cnt_d   = '0;
        level_d = level_q;
        push_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                push_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and debounce state; reset forces a fresh full debounce period.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            push_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= load_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            push_q  <= push_d;
            cnt_q   <= cnt_d;
        end
    end

    assign push_o = push_q;

endmodule

// File: rtl/cod2outof5_scan_display.sv
// Multi-digit 2-of-5 capture buffer multiplexed onto a common-anode display.
module cod2outof5_scan_display
    import cod2outof5_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int SCAN_DIV        = 1024,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          code_in,
    input  logic [2:0]          en_n,
    input  logic                load,
    input  logic                clear,
    output logic [6:0]          seg_n,
    output logic [N_DIGITS-1:0] dig_n,
    output logic                ledR,
    output logic                ledG,
    output logic [7:0]          err_count
);
    localparam int                IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [4:0]          code_s1_q, code_s2_q;
    logic [2:0]          en_s1_q, en_s2_q;
    logic                push;
    logic                enabled;
    decode_t             dec;

    entry_t              buf_q [N_DIGITS];
    entry_t              buf_d [N_DIGITS];
    logic                led_r_q, led_r_d;
    logic                led_g_q, led_g_d;
    logic [7:0]          err_q, err_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic [N_DIGITS-1:0] dig_n_q, dig_n_d;

    load_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .push_o (push)
    );

    assign enabled = (en_s2_q == 3'b000);
    assign dec     = decode_2of5(code_s2_q);

    // History shift, status LEDs and error count; clear beats a simultaneous push.
    always_comb begin
        buf_d   = buf_q;
        led_r_d = led_r_q;
        led_g_d = led_g_q;
        err_d   = err_q;
        if (clear) begin
            for (int i = 0; i < N_DIGITS; i++) buf_d[i] = ENTRY_BLANK;
            led_r_d = 1'b0;
            led_g_d = 1'b0;
        end else if (push && enabled) begin
            for (int i = N_DIGITS - 1; i > 0; i--) buf_d[i] = buf_q[i-1];
            if (dec.valid) begin
                buf_d[0] = '{state: DIGIT, value: dec.value};
                led_g_d  = 1'b1;
                led_r_d  = 1'b0;
            end else begin
                buf_d[0] = '{state: ERR, value: 4'd0};
                led_r_d  = 1'b1;
                led_g_d  = 1'b0;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end
    end

    // Scan divider/index and the next display word for the currently indexed slot.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        dig_n_d = '1;
        seg_n_d = 7'h7F;
        if (enabled) begin
            dig_n_d[idx_q] = 1'b0;
            seg_n_d        = ~glyph(buf_q[idx_q]);
        end
    end

    // All state: input synchronisers, buffer, scan counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_s1_q <= '0;
            code_s2_q <= '0;
            en_s1_q   <= '0;
            en_s2_q   <= '0;
            // NOTE: the history buffer is only N_DIGITS small entries of flops, so it is reset like any other register.
            for (int i = 0; i < N_DIGITS; i++) buf_q[i] <= ENTRY_BLANK;
            led_r_q   <= 1'b0;
            led_g_q   <= 1'b0;
            err_q     <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_n_q   <= 7'h7F;
            dig_n_q   <= '1;
        end else begin
            code_s1_q <= code_in;
            code_s2_q <= code_s1_q;
            en_s1_q   <= en_n;
            en_s2_q   <= en_s1_q;
            buf_q     <= buf_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            err_q     <= err_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_n_q   <= seg_n_d;
            dig_n_q   <= dig_n_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign dig_n     = dig_n_q;
    assign ledR      = led_r_q;
    assign ledG      = led_g_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_cod2outof5_scan_display.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks
// and randomized pushes, enables and clears.
module tb_cod2outof5_scan_display;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int HL = DB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    code_in = 5'b00000;
    logic [2:0]    en_n = 3'b000;
    logic          load = 1'b0;
    logic          clear = 1'b0;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_n;
    logic          ledR, ledG;
    logic [7:0]    err_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cod2outof5_scan_display #(
        .N_DIGITS(ND),
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .en_n      (en_n),
        .load      (load),
        .clear     (clear),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .ledR      (ledR),
        .ledG      (ledG),
        .err_count (err_count)
    );

    // Reference tables straight from the code/glyph definitions.
    logic [4:0] cw_tab  [10] = '{5'b00110, 5'b10001, 5'b01001, 5'b11000, 5'b00101,
                                 5'b10100, 5'b01100, 5'b00011, 5'b10010, 5'b01010};
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model value encoding: -1 blank, 0..9 digit, 10 error.
    function automatic int decode_m(input logic [4:0] c);
        for (int v = 0; v < 10; v++) if (cw_tab[v] == c) return v;
        return 10;
    endfunction

    function automatic logic [6:0] seg_m(input int e);
        if (e < 0) return 7'h00;
        if (e == 10) return 7'h79;
        return seg_tab[e];
    endfunction

    // ---------------- behavioural model ----------------
    int         mbuf [ND];
    bit         m_level, m_pend;
    int         m_t;
    logic       m_ld   [HL];
    logic [4:0] m_code [HL];
    logic [2:0] m_en   [HL];
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_r, e_g;
    int         e_err;
    bit         started = 1'b0;

    // Histories hold raw inputs per cycle; index 2 is what the synchronisers
    // present in the cycle that just ended.
    always @(posedge clk) begin
        bit en_ok;
        bit all_flip;
        int idx;
        int v;
        started = 1'b1;
        if (rst) begin
            for (int j = 0; j < HL; j++) begin
                m_ld[j] = 1'b0; m_code[j] = 5'b0; m_en[j] = 3'b0;
            end
            for (int i = 0; i < ND; i++) mbuf[i] = -1;
            m_level = 1'b0; m_pend = 1'b0; m_t = 0;
            e_seg = 7'h7F; e_dig = 4'hF; e_r = 1'b0; e_g = 1'b0; e_err = 0;
        end else begin
            for (int j = HL - 1; j > 0; j--) begin
                m_ld[j] = m_ld[j-1]; m_code[j] = m_code[j-1]; m_en[j] = m_en[j-1];
            end
            m_ld[0] = load; m_code[0] = code_in; m_en[0] = en_n;
            en_ok = (m_en[2] == 3'b000);
            idx = (m_t / SD) % ND;
            if (en_ok) begin
                e_dig = ~(4'b0001 << idx);
                e_seg = ~seg_m(mbuf[idx]);
            end else begin
                e_dig = 4'hF;
                e_seg = 7'h7F;
            end
            if (clear) begin
                for (int i = 0; i < ND; i++) mbuf[i] = -1;
                e_r = 1'b0; e_g = 1'b0;
            end else if (m_pend && en_ok) begin
                v = decode_m(m_code[2]);
                for (int i = ND - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
                mbuf[0] = v;
                if (v == 10) begin
                    e_r = 1'b1; e_g = 1'b0;
                    if (e_err < 255) e_err++;
                end else begin
                    e_g = 1'b1; e_r = 1'b0;
                end
            end
            // Level flips once the last DB synchronised samples all disagree with it.
            all_flip = 1'b1;
            for (int j = 2; j <= DB + 1; j++) if (m_ld[j] == m_level) all_flip = 1'b0;
            m_pend = 1'b0;
            if (all_flip) begin
                m_level = !m_level;
                m_pend  = m_level;
            end
            m_t++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("seg_n", 32'(seg_n), 32'(e_seg));
            check("dig_n", 32'(dig_n), 32'(e_dig));
            check("ledR", 32'(ledR), 32'(e_r));
            check("ledG", 32'(ledG), 32'(e_g));
            check("err_count", 32'(err_count), 32'(e_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_push(input logic [4:0] c, input bit clr_evt);
        @(posedge clk); #1;
        code_in = c;
        load    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        if (clr_evt) clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        load  = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    task automatic do_bounce(input logic [4:0] c, input bit lit);
        @(posedge clk); #1;
        code_in = c;
        load    = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        load = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        if (lit) check("bounce_not_early", 32'(ledR), 32'd0);
        @(posedge clk); #1;
        if (lit) check("bounce_on_time", 32'(ledR), 32'd1);
        @(posedge clk); #1;
        load = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    task automatic check_digit(input logic [3:0] pat, input logic [6:0] exp_seg, input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dig_n === pat) break;
        end
        check({name, "_sel"}, 32'(dig_n), 32'(pat));
        check(name, 32'(seg_n), 32'(exp_seg));
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [3:0] scan_pat [4];
        logic [4:0] five_codes [5];
        int op;
        scan_pat   = '{4'hE, 4'hD, 4'hB, 4'h7};
        five_codes = '{5'b10001, 5'b01001, 5'b11000, 5'b00101, 5'b10100};

        // Reset and blank scan.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_dig", 32'(dig_n), 32'hF);
        check("rst_ledR", 32'(ledR), 32'd0);
        check("rst_ledG", 32'(ledG), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("scan_dig", 32'(dig_n), 32'(scan_pat[(k / 4) % 4]));
            check("scan_blank", 32'(seg_n), 32'h7F);
        end

        // Valid pushes 0 then 1.
        do_push(5'b00110, 1'b0);
        do_push(5'b10001, 1'b0);
        check_digit(4'b1110, ~7'b0000110, "d0_is_1");
        check_digit(4'b1101, ~7'b0111111, "d1_is_0");
        check("ledG_after_valid", 32'(ledG), 32'd1);

        // Invalid push.
        do_push(5'b11100, 1'b0);
        check_digit(4'b1110, ~7'b1111001, "d0_is_err");
        check("ledR_after_invalid", 32'(ledR), 32'd1);
        check("ledG_after_invalid", 32'(ledG), 32'd0);
        check("err_one", 32'(err_count), 32'd1);

        // Bounce: exactly one push, 6 cycles after the final rising edge.
        pulse_clear();
        do_bounce(5'b11100, 1'b1);

        // Disabled: dark display, push ignored, contents intact afterwards.
        @(posedge clk); #1;
        en_n = 3'b100;
        repeat (4) @(posedge clk);
        #1;
        check("dis_dig", 32'(dig_n), 32'hF);
        check("dis_seg", 32'(seg_n), 32'h7F);
        do_push(5'b00101, 1'b0);
        en_n = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        check("dis_ledR_kept", 32'(ledR), 32'd1);
        check("dis_ledG_kept", 32'(ledG), 32'd0);
        check_digit(4'b1110, ~7'b1111001, "dis_d0_kept");
        check_digit(4'b1101, 7'h7F, "dis_d1_blank");

        // Clear coincident with push event.
        do_push(5'b00110, 1'b1);
        check("clr_ledR", 32'(ledR), 32'd0);
        check("clr_ledG", 32'(ledG), 32'd0);
        check("clr_err_kept", 32'(err_count), 32'd2);
        check_digit(4'b1110, 7'h7F, "clr_d0_blank");

        // Overflow: 1..5 leaves 2,3,4,5 left to right.
        for (int i = 0; i < 5; i++) do_push(five_codes[i], 1'b0);
        check_digit(4'b0111, ~7'h5B, "left_is_2");
        check_digit(4'b1110, ~7'h6D, "right_is_5");

        // Reset in the middle of a debounce with load held.
        @(posedge clk); #1;
        code_in = 5'b00110;
        load    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_push_yet", 32'(ledG), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_push", 32'(ledG), 32'd1);
        load = 1'b0;
        repeat (8) @(posedge clk);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: do_push(cw_tab[$urandom_range(0, 9)], ($urandom_range(0, 7) == 0));
                2:    do_push(5'($urandom_range(0, 31)), 1'b0);
                3:    do_bounce(5'($urandom_range(0, 31)), 1'b0);
                4: begin
                    @(posedge clk); #1;
                    en_n = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(0, 7));
                    repeat (int'($urandom_range(1, 6))) @(posedge clk);
                end
                default: begin
                    repeat (int'($urandom_range(0, 5))) @(posedge clk);
                    pulse_clear();
                end
            endcase
        end
        @(posedge clk); #1;
        en_n = 3'b000;
        repeat (4) @(posedge clk);

        // Saturation of the error counter.
        pulse_clear();
        for (int n = 0; n < 300; n++) do_push(5'b11100, 1'b0);
        #1;
        check("err_saturated", 32'(err_count), 32'd255);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
